// File: rtl/and10_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : and10_share_arbiter_if
// Brief    : Requester/detector bundle for the shared AND10 arbiter.
// Revision : 1.0
// ============================================================================
interface and10_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 10
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_flat;
    logic [WIDTH-1:0]      and_a;
    logic                  and_b;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  result;
    logic                  busy;

    // master: requesters plus the external detector; slave: the arbiter
    modport master (
        output req, op_flat, and_b,
        input  and_a, gnt, ack, result, busy
    );

    modport slave (
        input  req, op_flat, and_b,
        output and_a, gnt, ack, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/and10_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : and10_share_arbiter
// Brief    : Round-robin sharing of one external 10-input AND detector.
// Revision : 1.0
// ============================================================================
module and10_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 10
) (
    input  wire logic               MasterClock,
    input  wire logic               RESET,
    and10_share_arbiter_if.slave    bus
);
    localparam int c_LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [c_LW-1:0]  r_last, w_last_nxt, w_pick_idx;
    logic             w_pick_vld;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]  r_ack, w_ack_nxt;
    logic [WIDTH-1:0] r_and_a, w_and_a_nxt;
    logic             r_result, w_result_nxt;

    // Search starts just after the last winner and wraps
    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_pick_vld = 1'b0;
        w_pick_idx = r_last;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = (int'(r_last) + k) % NREQ;
            if (!w_pick_vld && bus.req[v_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = c_LW'(v_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_gnt_nxt    = r_gnt;
        w_ack_nxt    = r_ack;
        w_and_a_nxt  = r_and_a;
        w_result_nxt = r_result;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_gnt_nxt             = '0;
                    w_gnt_nxt[w_pick_idx] = 1'b1;
                    w_and_a_nxt           = bus.op_flat[int'(w_pick_idx)*WIDTH +: WIDTH];
                    w_last_nxt            = w_pick_idx;
                    w_state_nxt           = S_GRANT;
                end
            end
            S_GRANT: begin
                // and_a has been stable a full cycle, so the detector has settled
                w_result_nxt = bus.and_b;
                w_ack_nxt    = r_gnt;
                w_state_nxt  = S_ACK;
            end
            S_ACK: begin
                w_ack_nxt   = '0;
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_ack_nxt   = '0;
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge MasterClock) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_last   <= c_LW'(NREQ - 1);
            r_gnt    <= '0;
            r_ack    <= '0;
            r_and_a  <= '0;
            r_result <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ack    <= w_ack_nxt;
            r_and_a  <= w_and_a_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign bus.and_a  = r_and_a;
    assign bus.gnt    = r_gnt;
    assign bus.ack    = r_ack;
    assign bus.result = r_result;
    assign bus.busy   = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: doc/and10_share_arbiter.md
Name: and10_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 10-input AND detector (m_AND10 instance, outside this block) between NREQ requesters.
- Each requester presents a WIDTH-bit operand and needs to know whether all bits are 1, e.g. address/state-decode qualification.
- The block grants one requester, drives the detector inputs from registers, captures the detector output one cycle later, and returns the result with a one-cycle ack.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 10, operand width; must equal the detector input count.

Ports:
- MasterClock  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level; held until the matching ack.
- op_flat  input  NREQ*WIDTH  operands; requester i uses bits [i*WIDTH +: WIDTH]; held stable while req[i] is high.
- and_a  output  WIDTH  registered operand driven to the detector A_1..A_WIDTH (bit0 = A_1).
- and_b  input  1  detector output B.
- gnt  output  NREQ  one-hot grant, registered.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- result  output  1  captured detector output; valid while any ack bit is high, holds otherwise.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (RESET high at an edge):
  - state=IDLE; gnt=0; ack=0; result=0; and_a=0; busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Reset overrides any in-flight operation; no ack is issued for it.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req!=0 at an edge: choose the first i with req[i]=1, searching (last+1) mod NREQ upward with wrap.
  - On that edge: gnt<=onehot(i); and_a<=operand i; last<=i; state<=GRANT.
  - If req==0, stay in IDLE with outputs unchanged (and_a holds its previous value).
- GRANT:
  - and_a is stable for this full cycle, so the detector settles.
  - At the edge: result<=and_b; ack<=gnt; state<=ACK.
- ACK:
  - ack is high for exactly this one cycle.
  - At the edge: ack<=0; gnt<=0; state<=IDLE.
  - req is ignored in this cycle. The requester drops req on seeing ack; a requester that keeps req high is re-arbitrated in the next IDLE cycle.
- Timing:
  - Latency: req sampled at edge N; ack high during the cycle after edge N+1 (2 cycles req-to-ack).
  - Maximum throughput: one operation per 3 cycles.
- Operand capture: the operand is captured once at grant. Changes to op_flat after grant do not affect the result.
- Request withdrawal: if req[i] drops during GRANT, the operation still completes and ack[i] still pulses.
- Fairness: a requester with req continuously high waits at most NREQ-1 other grants.
- Simultaneous requests: resolved solely by the round-robin search. There is no fixed priority except at the first arbitration after reset.
- Output invariants: gnt and ack are always one-hot or zero. busy = (state!=IDLE).

Test Plan:
- Reset mid-operation: RESET asserted during GRANT -> next cycle state IDLE, gnt=0, ack=0, result=0, busy=0; no ack is ever emitted for the aborted grant.
- Single requester, all ones: req=0001, op0=0x3FF -> gnt=0001 one cycle after the req edge, and_a=0x3FF, ack=0001 and result=1 one cycle later, busy low after the ack cycle.
- Single requester, one zero bit: req=0100, op2=0x3FE -> and_a=0x3FE, ack=0100, result=0 (bit0 low drives A_1 low).
- Round-robin rotation: req=1111 held continuously, all operands distinct -> grant order 0,1,2,3,0 with one ack each every 3 cycles; verify the wrap from 3 to 0.
- Operand change and withdrawal after grant: req[1] with op1=0x3FF granted, then op1 changed to 0x000 and req[1] dropped during GRANT -> and_a stays 0x3FF, result=1, ack=0010 still pulses.
- Rearbitration from the pointer: last=2, then req=0101 -> grant goes to requester 0 (search order 3,0,1,2), and the next arbitration with req=0100 grants requester 2.
